// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps a small instruction FIFO fed from a
// 1-cycle synchronous InstructionMem, and handles redirect/flush/halt. Optional perf counters: IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_rd_en,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;

    logic            pop;
    logic            push;
    logic [CW:0]     occ;
    logic            room;

    // Occupancy after this cycle's pop, counting the response still in flight.
    assign pop  = inst_valid & inst_ready;
    assign push = inflight & ~redirect_valid;
    assign occ  = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign room = occ < DEPTH_V;

    assign imem_rd_en = (state == FETCH) & ~halt & ~redirect_valid & room;
    assign imem_addr  = pc;

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

    // NOTE: FIFO storage has no reset; the head outputs are gated by inst_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (halt)  state <= HALTED;
                HALTED:  if (!halt) state <= FETCH;
                default: state <= IDLE;
            endcase

            inflight <= imem_rd_en;
            if (imem_rd_en) inflight_pc <= pc;

            if (redirect_valid) begin
                pc     <= redirect_pc & ~XLEN'(3);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (imem_rd_en) pc <= pc + XLEN'(4);
                if (push)       wr_ptr <= wr_ptr + PW'(1);
                if (pop)        rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    // A redirect discards whatever the FIFO holds beyond this cycle's pop, plus the landing response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (imem_rd_en) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid)
                perf_flush_cnt <= perf_flush_cnt + 32'(count) - 32'(pop) + 32'(inflight);
        end
    end
`endif

endmodule
